// File: rtl/bcd_serial_collector_pkg.sv
// Shared constants and the seven-segment decoder used by the BCD collector
// and the display stage.
package bcd_pkg;

   localparam logic [3:0] E3_MIN    = 4'd3;
   localparam logic [3:0] E3_MAX    = 4'd12;
   localparam logic [3:0] E3_BIAS   = 4'd3;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // {g,f,e,d,c,b,a}, active-high; non-BCD codes blank the display
   function automatic logic [6:0] seg7_decode(input logic [3:0] d);
      logic [6:0] s;
      s = SEG_BLANK;
      case (d)
         4'd0: s = 7'h3F;
         4'd1: s = 7'h06;
         4'd2: s = 7'h5B;
         4'd3: s = 7'h4F;
         4'd4: s = 7'h66;
         4'd5: s = 7'h6D;
         4'd6: s = 7'h7D;
         4'd7: s = 7'h07;
         4'd8: s = 7'h7F;
         4'd9: s = 7'h6F;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bcd_serial_collector_if.sv
// Serial tap (X/Z) plus the published digit/status bundle.
interface bcd_serial_collector_if #(
   parameter int NDIG  = 2,
   parameter int CNT_W = 8
);
   logic                X;
   logic                Z;
   logic [3:0]          Digit;
   logic                Valid;
   logic                Err;
   logic                Mism;
   logic [6:0]          Seg;
   logic [4*NDIG-1:0]   Hist;
   logic [CNT_W-1:0]    Count;

   modport master (output X, Z,
                   input  Digit, Valid, Err, Mism, Seg, Hist, Count);
   modport slave  (input  X, Z,
                   output Digit, Valid, Err, Mism, Seg, Hist, Count);
endinterface

// File: rtl/bcd_serial_collector_sipo.sv
// LSB-first serial-to-nibble converter; nibble is valid when frame_done is
// high and already includes the bit currently on din.
module serial_nibble_sipo (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       din,
   output logic [3:0] nibble,
   output logic       frame_done
);

   logic [1:0] cnt;
   logic [2:0] sr;

   // bit position counter and storage of the first three bits
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         cnt <= 2'd0;
         sr  <= 3'd0;
      end else begin
         if (cnt != 2'd3) sr[cnt] <= din;
         cnt <= cnt + 2'd1;
      end
   end

   assign nibble     = {din, sr};
   assign frame_done = (cnt == 2'd3);

endmodule

// File: rtl/bcd_serial_collector.sv
// Collects Excess-3 input and BCD output of the serial converter, checks
// each 4-bit frame and publishes digit, segments, history and count.
module bcd_serial_collector
   import bcd_pkg::*;
#(
   parameter int NDIG  = 2,
   parameter int CNT_W = 8
) (
   input logic                    Clk,
   input logic                    Rst,
   bcd_serial_collector_if.slave  bus
);

   localparam int NUM_LANES = 2;   // lane 0: X (Excess-3), lane 1: Z (BCD)

   logic [NUM_LANES-1:0]       lane_din;
   logic [NUM_LANES-1:0][3:0]  lane_nib;
   logic [NUM_LANES-1:0]       lane_done;

   assign lane_din = {bus.Z, bus.X};

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      serial_nibble_sipo u_sipo (
         .Clk        (Clk),
         .Rst        (Rst),
         .din        (lane_din[l]),
         .nibble     (lane_nib[l]),
         .frame_done (lane_done[l])
      );
   end

   logic [3:0] e3, b;
   logic       frame_done;
   logic       chk_err, chk_mism, chk_good;

   assign e3         = lane_nib[0];
   assign b          = lane_nib[1];
   assign frame_done = &lane_done;   // both lanes share reset, so they agree

   // classify the frame currently completing
   always_comb begin
      chk_err  = 1'b0;
      chk_mism = 1'b0;
      chk_good = 1'b0;
      if (e3 < E3_MIN || e3 > E3_MAX) chk_err  = 1'b1;
      else if (b != e3 - E3_BIAS)     chk_mism = 1'b1;
      else                            chk_good = 1'b1;
   end

   logic [3:0]        digit;
   logic              valid, err, mism;
   logic [6:0]        seg;
   logic [4*NDIG-1:0] hist, hist_nxt;
   logic [CNT_W-1:0]  count;

   // newest digit enters at [3:0]; single-digit history is just the digit
   if (NDIG == 1) begin : g_hist1
      assign hist_nxt = b;
   end else begin : g_histn
      assign hist_nxt = {hist[4*NDIG-5:0], b};
   end

   // registered outputs: pulses last one cycle, state moves on good frames
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         digit <= 4'd0;
         valid <= 1'b0;
         err   <= 1'b0;
         mism  <= 1'b0;
         seg   <= SEG_BLANK;
         hist  <= '0;
         count <= '0;
      end else begin
         valid <= 1'b0;
         err   <= 1'b0;
         mism  <= 1'b0;
         if (frame_done) begin
            digit <= b;
            err   <= chk_err;
            mism  <= chk_mism;
            valid <= chk_good;
            if (chk_good) begin
               seg  <= seg7_decode(b);
               hist <= hist_nxt;
               if (count != '1) count <= count + CNT_W'(1);
            end
         end
      end
   end

   assign bus.Digit = digit;
   assign bus.Valid = valid;
   assign bus.Err   = err;
   assign bus.Mism  = mism;
   assign bus.Seg   = seg;
   assign bus.Hist  = hist;
   assign bus.Count = count;

endmodule

// File: doc/bcd_serial_collector.md
Name: bcd_serial_collector

Overview:
Downstream stage of the serial Excess-3-to-BCD converter. Taps the converter's serial input X and output Z, both LSB first and 4 bits per digit. Deserialises each 4-bit frame and checks it: the Excess-3 code must be legal and the BCD result must equal Excess3 − 3. Publishes the good digit, a seven-segment pattern, a packed history of recent digits and a good-digit counter for the display/scoreboard stage.

Parameters:
NDIG, 2, number of BCD digits kept in history shift register (≥1)
CNT_W, 8, width of saturating good-digit counter

Ports:
Clk  input  1  system clock; all sampling on posedge
Rst  input  1  asynchronous, active-low reset
X  input  1  serial Excess-3 bit, same stream the converter consumes
Z  input  1  serial BCD bit produced by converter for current X
Digit  output  4  last captured BCD nibble (any frame outcome)
Valid  output  1  1-cycle pulse: frame legal and consistent
Err  output  1  1-cycle pulse: Excess-3 code outside 3..12
Mism  output  1  1-cycle pulse: legal code but BCD != Excess3−3
Seg  output  7  {g,f,e,d,c,b,a}, active-high, last good digit
Hist  output  4*NDIG  packed BCD history of good digits, newest in [3:0]
Count  output  CNT_W  number of good digits, saturating

Behaviour:
- Reset (Rst=0, async): bit counter=0, shift regs=0, Digit=0, Valid/Err/Mism=0, Seg=7'h00 (blank), Hist=0, Count=0. Outputs are held while Rst is low.
- Frame alignment: the bit counter (0..3) starts at 0 on the first posedge after Rst deasserts. This matches the converter, whose state also restarts on the same Rst. No other sync mechanism.
- Each posedge with Rst=1: sample X and Z into e3_sr / bcd_sr at position cnt, then cnt=(cnt+1) mod 4.
- Frame completion at cnt==3 posedge:
  - The frame uses E3={X,e3_sr[2:0]} and B={Z,bcd_sr[2:0]}.
  - Digit<=B in all cases.
  - If E3<3 or E3>12: Err<=1; nothing else updates.
  - Else if B != E3−3 (4-bit): Mism<=1; nothing else updates.
  - Else: Valid<=1; Seg<=decode(B); Hist<={Hist[4*NDIG-5:0],B}; Count<=Count+1 unless all-ones.
- Pulse timing: the pulses go high at the frame-completion posedge and return to 0 at the next posedge. Exactly one of Valid/Err/Mism pulses per completed frame; none pulse on the other three bits.
- Latency: 0 cycles after 4th bit sampled. Registered outputs, no combinational path from X/Z to outputs.
- Seg decode (hex, a=bit0): 0→3F 1→06 2→5B 3→4F 4→66 5→6D 6→7D 7→07 8→7F 9→6F. Seg is only updated from valid frames, so B≤9 always.
- Reset mid-frame: the partial frame is discarded with no pulse. A pulse active at reset assertion is cleared immediately.
- Count saturation: at 2^CNT_W−1, further valid frames still update Digit/Seg/Hist and pulse Valid, but Count holds.
- NDIG=1: Hist equals the last good digit.

Decomposition:
- Shared package bcd_pkg:
  - constants E3_MIN=4'd3, E3_MAX=4'd12, E3_BIAS=4'd3
  - SEG_BLANK=7'h00
  - function seg7_decode(4-bit)→7-bit (shared with the display stage)
- One natural sub-module: serial_nibble_sipo. Contains the 2-bit counter and the 4-bit shift register, outputs nibble plus frame_done. Instantiated twice (X path, Z path), or once with a 2-bit-wide data path.
- Check, history and counter logic stay in the top.

Test Plan:
- Rst low then high; X LSB-first 1,1,1,0 (E3=7), Z 0,0,1,0 (B=4) -> at 4th posedge Valid=1 for one cycle, Digit=4, Seg=66, Hist[3:0]=4, Count=1; Err=Mism=0.
- X 1,1,1,1 (E3=15), any Z -> Err pulse only, Valid=0, Seg/Hist/Count unchanged, Digit=captured Z nibble.
- X for E3=7, Z forced 1,0,1,0 (B=5) -> Mism pulse only, Count unchanged, Seg unchanged.
- Two bits of a frame, Rst low for 3 ns mid-cycle, then E3=12/B=9 frame -> no pulse from partial frame; Valid at 4th post-reset posedge, Seg=6F, all state cleared first.
- NDIG=2: good digits 4 then 9 -> Hist=8'h49. Third digit 0 -> Hist=8'h90, Seg=3F.
- CNT_W=4: 17 consecutive good frames -> Count stays 4'hF after 15th, Valid pulses on all 17.
